fsweep_ctrl: RTL and testbench



---
 rtl/ddfs_pkg.sv | 18 +
 rtl/fsweep_ctrl_if.sv | 38 +++
 rtl/fsweep_ctrl_dwell_timer.sv | 57 +++++
 rtl/fsweep_ctrl.sv | 131 +++++++++++++
 tb/tb_fsweep_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ddfs_pkg.sv
// ---------------------------------------------------------------------------
// ddfs_pkg
// Shared definitions for the DDFS datapath and its frequency-sweep controller.
//   FCW_W         : frequency control word width (matches the DDFS fcontrol)
//   DWELL_W       : default dwell counter width for the sweep controller
//   sweep_state_t : sweep controller FSM states
// ---------------------------------------------------------------------------
package ddfs_pkg;

    localparam int FCW_W   = 23;
    localparam int DWELL_W = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } sweep_state_t;

endpackage : ddfs_pkg

// File: rtl/fsweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// fsweep_ctrl_if
// Control/status bundle between a host (or test sequencer) and fsweep_ctrl.
//   start, stop               : command pulses from the host
//   f_start, f_stop, f_step   : sweep configuration words
//   dwell, mode               : hold time per word, one-shot/continuous select
//   fcontrol                  : frequency word towards the DDFS
//   busy, done, step_strobe   : status back to the host
// Modports: master = host side, slave = sweep controller side.
// ---------------------------------------------------------------------------
interface fsweep_ctrl_if #(
    parameter int FCW_W   = ddfs_pkg::FCW_W,
    parameter int DWELL_W = ddfs_pkg::DWELL_W
);

    logic               start;
    logic               stop;
    logic [FCW_W-1:0]   f_start;
    logic [FCW_W-1:0]   f_stop;
    logic [FCW_W-1:0]   f_step;
    logic [DWELL_W-1:0] dwell;
    logic               mode;
    logic [FCW_W-1:0]   fcontrol;
    logic               busy;
    logic               done;
    logic               step_strobe;

    modport master (
        output start, stop, f_start, f_stop, f_step, dwell, mode,
        input  fcontrol, busy, done, step_strobe
    );

    modport slave (
        input  start, stop, f_start, f_stop, f_step, dwell, mode,
        output fcontrol, busy, done, step_strobe
    );

endinterface : fsweep_ctrl_if

// File: rtl/fsweep_ctrl_dwell_timer.sv
// ---------------------------------------------------------------------------
// fsweep_ctrl_dwell_timer
// Dwell counter for the sweep controller. Counts 0..limit and flags the last
// cycle of each dwell period with a registered expiry bit.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : force counter to 0 and drop expiry (idle / abort)
//   i_load    : start a fresh dwell period at count 0
//   i_en      : advance the counter (sweep active)
//   i_limit   : dwell limit that applies from the next cycle on
//   o_expire  : high during the last cycle of the dwell period
// ---------------------------------------------------------------------------
module fsweep_ctrl_dwell_timer #(
    parameter int DWELL_W = ddfs_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_limit,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;
    logic               r_expire;
    logic [DWELL_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + DWELL_W'(1);

    // The expiry flag is computed one cycle ahead from the counter's next
    // value, so it is a flop output yet lines up with count == limit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_expire <= (i_limit == '0);
        end else if (i_en) begin
            if (r_expire) begin
                r_cnt    <= '0;
                r_expire <= (i_limit == '0);
            end else begin
                r_cnt    <= w_cnt_inc;
                r_expire <= (w_cnt_inc == i_limit);
            end
        end
    end

    assign o_expire = r_expire;

endmodule : fsweep_ctrl_dwell_timer

// File: rtl/fsweep_ctrl.sv
// ---------------------------------------------------------------------------
// fsweep_ctrl
// Linear frequency-sweep controller feeding the DDFS frequency control word.
// Steps fcontrol from f_start to f_stop (inclusive, clamped) by f_step, each
// word held for dwell+1 cycles; one-shot or continuous, abortable by stop.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : fsweep_ctrl_if.slave (commands, config, fcontrol and status)
// All outputs are registered.
// ---------------------------------------------------------------------------
module fsweep_ctrl #(
    parameter int FCW_W   = ddfs_pkg::FCW_W,
    parameter int DWELL_W = ddfs_pkg::DWELL_W
) (
    input  logic         clk,
    input  logic         rst,
    fsweep_ctrl_if.slave bus
);

    import ddfs_pkg::*;

    sweep_state_t       r_state;
    logic [FCW_W-1:0]   r_fcontrol;
    logic [FCW_W-1:0]   r_f_start_lat;
    logic [FCW_W-1:0]   r_f_stop_lat;
    logic [FCW_W-1:0]   r_f_step_lat;
    logic [DWELL_W-1:0] r_dwell_lat;
    logic               r_mode_lat;
    logic               r_busy;
    logic               r_done;
    logic               r_step_strobe;

    logic               w_accept;
    logic               w_abort;
    logic               w_expire;
    logic [DWELL_W-1:0] w_limit;
    logic [FCW_W:0]     w_sum;
    logic               w_at_end;
    logic [FCW_W-1:0]   w_next_word;

    // stop outranks start, so a simultaneous pair in IDLE does nothing.
    assign w_accept = (r_state == S_IDLE)  && bus.start && !bus.stop;
    assign w_abort  = (r_state == S_DWELL) && bus.stop;

    // On the accepting edge the latched dwell is not yet valid, so the timer
    // is handed the incoming value directly.
    assign w_limit  = w_accept ? bus.dwell : r_dwell_lat;

    // One extra bit keeps the carry-out, so an overflowing step clamps to
    // f_stop instead of wrapping to a small word.
    assign w_sum       = {1'b0, r_fcontrol} + {1'b0, r_f_step_lat};
    assign w_at_end    = (r_fcontrol >= r_f_stop_lat);
    assign w_next_word = (w_sum >= {1'b0, r_f_stop_lat}) ? r_f_stop_lat
                                                         : w_sum[FCW_W-1:0];

    fsweep_ctrl_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (((r_state == S_IDLE) && !w_accept) || w_abort),
        .i_load   (w_accept),
        .i_en     (r_state == S_DWELL),
        .i_limit  (w_limit),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fcontrol    <= '0;
            r_f_start_lat <= '0;
            r_f_stop_lat  <= '0;
            r_f_step_lat  <= '0;
            r_dwell_lat   <= '0;
            r_mode_lat    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_step_strobe <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            r_done        <= 1'b0;
            r_step_strobe <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f_start_lat <= bus.f_start;
                        r_f_stop_lat  <= bus.f_stop;
                        r_f_step_lat  <= bus.f_step;
                        r_dwell_lat   <= bus.dwell;
                        r_mode_lat    <= bus.mode;
                        r_fcontrol    <= bus.f_start;
                        r_busy        <= 1'b1;
                        r_state       <= S_DWELL;
                    end
                end

                S_DWELL: begin
                    if (bus.stop) begin
                        // Abort: freeze the word, no completion pulse.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        if (w_at_end) begin
                            if (r_mode_lat) begin
                                r_fcontrol    <= r_f_start_lat;
                                r_step_strobe <= 1'b1;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_fcontrol    <= w_next_word;
                            r_step_strobe <= 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fcontrol    = r_fcontrol;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.step_strobe = r_step_strobe;

endmodule : fsweep_ctrl

// File: tb/tb_fsweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fsweep_ctrl
// Self-checking bench for fsweep_ctrl. A table of sweep configurations is
// run back to back; for each one a cycle-by-cycle expectation trace is
// pushed into a queue when start is driven and popped on every DUT cycle.
// Hand-written sequences cover start+stop in IDLE and reset mid-sweep.
// ---------------------------------------------------------------------------
module tb_fsweep_ctrl;

    localparam int FCW_W   = 23;
    localparam int DWELL_W = 16;

    typedef struct packed {
        logic [FCW_W-1:0] fc;
        logic             busy;
        logic             strobe;
        logic             done;
    } obs_t;

    typedef struct {
        string              name;
        logic [FCW_W-1:0]   f_start;
        logic [FCW_W-1:0]   f_stop;
        logic [FCW_W-1:0]   f_step;
        logic [DWELL_W-1:0] dwell;
        logic               mode;
        int                 max_cyc;      // >0: abort with stop after this many sweep cycles
        int                 exp_strobes;  // hand-derived step_strobe count
    } vec_t;

    logic clk;
    logic rst;

    fsweep_ctrl_if #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) bus ();

    fsweep_ctrl #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t             exp_q[$];
    logic [FCW_W-1:0] last_fc;
    int               n_total;
    int               n_pass;
    vec_t             vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.fc     = bus.fcontrol;
        o.busy   = bus.busy;
        o.strobe = bus.step_strobe;
        o.done   = bus.done;
        return o;
    endfunction

    function automatic obs_t mk(input logic [FCW_W-1:0] fc, input logic b, input logic s, input logic d);
        obs_t o;
        o.fc = fc; o.busy = b; o.strobe = s; o.done = d;
        return o;
    endfunction

    // Expected per-cycle behaviour, starting with the cycle after the start edge.
    task automatic build(input vec_t v, output int abort_at);
        logic [FCW_W-1:0] cur;
        logic [FCW_W:0]   n;
        int               cyc;
        bit               first;
        bit               fin;
        cur = v.f_start; cyc = 0; first = 1'b1; fin = 1'b0; abort_at = -1;
        while (!fin) begin
            for (int d = 0; d <= int'(v.dwell) && !fin; d++) begin
                exp_q.push_back(mk(cur, 1'b1, (d == 0) && !first, 1'b0));
                cyc++;
                if (v.max_cyc > 0 && cyc >= v.max_cyc) begin
                    abort_at = cyc;
                    exp_q.push_back(mk(cur, 1'b0, 1'b0, 1'b0));
                    exp_q.push_back(mk(cur, 1'b0, 1'b0, 1'b0));
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                first = 1'b0;
                if (cur >= v.f_stop) begin
                    if (!v.mode) begin
                        exp_q.push_back(mk(cur, 1'b0, 1'b0, 1'b1));
                        exp_q.push_back(mk(cur, 1'b0, 1'b0, 1'b0));
                        fin = 1'b1;
                    end else begin
                        cur = v.f_start;
                    end
                end else begin
                    n   = {1'b0, cur} + {1'b0, v.f_step};
                    cur = (n >= {1'b0, v.f_stop}) ? v.f_stop : n[FCW_W-1:0];
                end
            end
        end
        last_fc = cur;
    endtask

    task automatic run(input vec_t v);
        int   abort_at;
        int   idx;
        int   n_strobe;
        obs_t e;
        obs_t a;
        build(v, abort_at);
        bus.f_start = v.f_start;
        bus.f_stop  = v.f_stop;
        bus.f_step  = v.f_step;
        bus.dwell   = v.dwell;
        bus.mode    = v.mode;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Config changes after start must be ignored.
        bus.f_start = FCW_W'($urandom);
        bus.f_stop  = FCW_W'($urandom);
        bus.f_step  = FCW_W'($urandom);
        bus.dwell   = DWELL_W'($urandom_range(0, 5));
        bus.mode    = ~v.mode;
        idx = 0; n_strobe = 0;
        while (exp_q.size() > 0) begin
            if (idx > 0) @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            e = exp_q.pop_front();
            a = sample();
            check({v.name, "/cycle"}, 32'(a), 32'(e));
            n_strobe += int'(a.strobe);
            if (idx == abort_at - 1) bus.stop = 1'b1;
            // Start while busy must be ignored.
            if (idx == 1 && exp_q.size() > 0 && exp_q[0].busy) bus.start = 1'b1;
            idx++;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check({v.name, "/strobes"}, 32'(n_strobe), 32'(v.exp_strobes));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0; n_pass = 0;
        vecs[0] = '{"oneshot",  23'd1000,     23'd1300,     23'd100,  16'd2, 1'b0, 0, 3};
        vecs[1] = '{"clamp",    23'd0,        23'd250,      23'd100,  16'd0, 1'b0, 0, 3};
        vecs[2] = '{"carry",    23'h7FFF00,   23'h7FFFFF,   23'h80,   16'd0, 1'b0, 0, 2};
        vecs[3] = '{"stop_lt",  23'd500,      23'd100,      23'd7,    16'd1, 1'b0, 0, 0};
        vecs[4] = '{"contin",   23'd10,       23'd30,       23'd10,   16'd0, 1'b1, 8, 7};
        vecs[5] = '{"zerostep", 23'd5,        23'd100,      23'd0,    16'd1, 1'b0, 6, 2};
        vecs[6] = '{"cont_dw",  23'd40,       23'd60,       23'd15,   16'd1, 1'b1, 9, 4};

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0; bus.mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", 32'(sample()), 32'(mk('0, 1'b0, 1'b0, 1'b0)));

        foreach (vecs[i]) run(vecs[i]);

        // start and stop together in IDLE: stop wins, nothing changes.
        bus.f_start = 23'd777; bus.f_stop = 23'd900; bus.f_step = 23'd1; bus.dwell = '0; bus.mode = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_idle", 32'(sample()), 32'(mk(last_fc, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        check("start_stop_idle2", 32'(sample()), 32'(mk(last_fc, 1'b0, 1'b0, 1'b0)));

        // Reset in the middle of a sweep.
        bus.f_start = 23'd1000; bus.f_stop = 23'd5000; bus.f_step = 23'd100; bus.dwell = 16'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("pre_rst_busy", 32'(sample()), 32'(mk(23'd1000, 1'b1, 1'b0, 1'b0)));
        repeat (3) @(negedge clk);
        check("pre_rst_step", 32'(sample()), 32'(mk(23'd1100, 1'b1, 1'b0, 1'b0)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_sweep", 32'(sample()), 32'(mk('0, 1'b0, 1'b0, 1'b0)));
        repeat (3) @(negedge clk);
        check("rst_stays_idle", 32'(sample()), 32'(mk('0, 1'b0, 1'b0, 1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fsweep_ctrl
